// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - RV32I instruction-fetch front end feeding the IF/ID register
// Issues in-order imem requests, pairs responses with their PCs and honours stall/redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        valid_f
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic          started_q;
  logic [31:0]   pc_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] drop_q;

  // PCs of granted requests whose responses will be kept
  logic [31:0]   pcq_mem [DEPTH];
  logic [AW-1:0] pcq_wr;
  logic [AW-1:0] pcq_rd;

  logic [31:0]   ib_instr [DEPTH];
  logic [31:0]   ib_pc    [DEPTH];
  logic [AW-1:0] ib_wr;
  logic [AW-1:0] ib_rd;
  logic [CW-1:0] ib_cnt;

  logic          rsp_ok;
  logic          drop_rsp;
  logic          keep_rsp;
  logic          pop;
  logic          grant;
  logic [CW:0]   occ;
  logic [31:0]   redirect_base;

  assign redirect_base = redirect_pc & 32'hFFFF_FFFC;
  assign rsp_ok        = imem_rvalid & (outstanding_q != '0);
  assign drop_rsp      = rsp_ok & (drop_q != '0);
  assign keep_rsp      = rsp_ok & (drop_q == '0);
  assign valid_f       = (ib_cnt != '0);
  assign pop           = valid_f & ~stall;

  // A head leaving this cycle frees its slot, so back-to-back fetch is sustained at DEPTH=2
  assign occ      = {1'b0, outstanding_q} + {1'b0, ib_cnt} - {{CW{1'b0}}, pop};
  assign imem_req = started_q & ~redirect & (occ < DEPTH_W);
  assign grant    = imem_req & imem_gnt;
  assign imem_addr = pc_q;

  assign InstrF   = valid_f ? ib_instr[ib_rd]         : 32'h0;
  assign PCF      = valid_f ? ib_pc[ib_rd]            : 32'h0;
  assign PCPlus4F = valid_f ? (ib_pc[ib_rd] + 32'd4)  : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_q     <= 1'b0;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      pcq_wr        <= '0;
      pcq_rd        <= '0;
      ib_wr         <= '0;
      ib_rd         <= '0;
      ib_cnt        <= '0;
    end else begin
      started_q     <= 1'b1;
      outstanding_q <= outstanding_q + {{AW{1'b0}}, grant} - {{AW{1'b0}}, rsp_ok};
      if (redirect) begin
        // Whatever is still in flight after this cycle belongs to the old path
        pc_q   <= redirect_base;
        drop_q <= outstanding_q - {{AW{1'b0}}, rsp_ok};
        pcq_wr <= '0;
        pcq_rd <= '0;
        ib_wr  <= '0;
        ib_rd  <= '0;
        ib_cnt <= '0;
      end else begin
        if (grant) begin
          pc_q   <= pc_q + 32'd4;
          pcq_wr <= pcq_wr + PTR_ONE;
        end
        if (drop_rsp) begin
          drop_q <= drop_q - CNT_ONE;
        end
        if (keep_rsp) begin
          pcq_rd <= pcq_rd + PTR_ONE;
          ib_wr  <= ib_wr + PTR_ONE;
        end
        if (pop) begin
          ib_rd <= ib_rd + PTR_ONE;
        end
        ib_cnt <= ib_cnt + {{AW{1'b0}}, keep_rsp} - {{AW{1'b0}}, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      pcq_mem[pcq_wr] <= pc_q;
    end
    if (keep_rsp & ~redirect) begin
      ib_instr[ib_wr] <= imem_rdata;
      ib_pc[ib_wr]    <= pcq_mem[pcq_rd];
    end
  end

endmodule
